// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART receive path.
//   UART_DATA_W   - width of a received byte
//   RX_FIFO_DEPTH - default receive FIFO depth (power of two)
//   RX_FIFO_AF    - default almost-full threshold
//   err_bit()     - bit position of the framing-error flag in a FIFO entry
//                   packed as {err, data}
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AF    = 12;

  // The error flag sits directly above the data byte.
  function automatic int err_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, occupancy and overflow bookkeeping for rx_fifo.
// Ports:
//   clk, reset       - clock, synchronous active-low reset
//   wr_tick          - push request
//   rd_ready         - consumer accepts the head entry
//   flush            - discard all entries
//   clr_overflow     - clear the sticky overflow flag
//   wr_en            - storage write enable at wr_ptr
//   wr_ptr, rd_ptr   - storage addresses
//   count            - occupancy 0..DEPTH
//   rd_valid, full, almost_full, overflow - status
module fifo_ptr_ctrl #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_tick,
  input  logic              rd_ready,
  input  logic              flush,
  input  logic              clr_overflow,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              rd_valid,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);

  localparam int CNT_W = ADDR_W + 1;

  logic pop;
  logic push;
  logic drop;

  assign rd_valid    = (count != '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (count >= CNT_W'(AF_LEVEL));

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop  = rd_valid & rd_ready;
  assign push = wr_tick & (~full | pop);
  assign drop = wr_tick & ~push;

  // Storage write is suppressed on flush and reset so no entry is written
  // behind pointers that are being cleared.
  assign wr_en = push & ~flush & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Flush leaves the overflow history alone; only an explicit clear does.
      if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      // A drop in the same cycle as a clear wins so no loss goes unreported.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: first-word-fall-through receive buffer behind the UART deframer.
// Each entry holds {err, data}. Head entry is a combinational read.
// Ports:
//   clk, reset                  - clock, synchronous active-low reset
//   iWr_tick, iWr_data, iWr_err - push strobe, byte, framing-error flag
//   iRd_ready                   - consumer accepts head entry
//   oRd_valid, oRd_data, oRd_err - head entry
//   oCount, oFull, oAlmost_full - occupancy status
//   oOverflow, iClr_overflow    - sticky dropped-byte flag and its clear
//   iFlush                      - discard all entries
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = RX_FIFO_DEPTH,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = RX_FIFO_AF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iWr_tick,
  input  logic [DATA_W-1:0] iWr_data,
  input  logic              iWr_err,
  input  logic              iRd_ready,
  output logic              oRd_valid,
  output logic [DATA_W-1:0] oRd_data,
  output logic              oRd_err,
  output logic [ADDR_W:0]   oCount,
  output logic              oFull,
  output logic              oAlmost_full,
  output logic              oOverflow,
  input  logic              iClr_overflow,
  input  logic              iFlush
);

  localparam int ERR_POS = err_bit(DATA_W);

  logic [DATA_W:0]   mem [DEPTH];
  logic [DATA_W:0]   head;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF_LEVEL)
  ) u_ptr_ctrl (
    .clk          (clk),
    .reset        (reset),
    .wr_tick      (iWr_tick),
    .rd_ready     (iRd_ready),
    .flush        (iFlush),
    .clr_overflow (iClr_overflow),
    .wr_en        (wr_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (oCount),
    .rd_valid     (oRd_valid),
    .full         (oFull),
    .almost_full  (oAlmost_full),
    .overflow     (oOverflow)
  );

  // Storage is intentionally not reset; the head is only meaningful when
  // oRd_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {iWr_err, iWr_data};
    end
  end

  assign head     = mem[rd_ptr];
  assign oRd_data = head[DATA_W-1:0];
  assign oRd_err  = head[ERR_POS];

endmodule

// File: tb/tb_rx_fifo.sv
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       iWr_tick;
  logic [7:0] iWr_data;
  logic       iWr_err;
  logic       iRd_ready;
  logic       oRd_valid;
  logic [7:0] oRd_data;
  logic       oRd_err;
  logic [4:0] oCount;
  logic       oFull;
  logic       oAlmost_full;
  logic       oOverflow;
  logic       iClr_overflow;
  logic       iFlush;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {err, data} entries and the sticky flag.
  logic [8:0] q[$];
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  rx_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .iWr_tick      (iWr_tick),
    .iWr_data      (iWr_data),
    .iWr_err       (iWr_err),
    .iRd_ready     (iRd_ready),
    .oRd_valid     (oRd_valid),
    .oRd_data      (oRd_data),
    .oRd_err       (oRd_err),
    .oCount        (oCount),
    .oFull         (oFull),
    .oAlmost_full  (oAlmost_full),
    .oOverflow     (oOverflow),
    .iClr_overflow (iClr_overflow),
    .iFlush        (iFlush)
  );

  // One clock cycle of stimulus; the model advances by the queue rules.
  task automatic step(input logic wt, input logic [7:0] wd, input logic we,
                      input logic rr, input logic fl = 1'b0,
                      input logic clr = 1'b0, input logic rst = 1'b1);
    bit pop, push, drop;
    iWr_tick      = wt;
    iWr_data      = wd;
    iWr_err       = we;
    iRd_ready     = rr;
    iFlush        = fl;
    iClr_overflow = clr;
    reset         = rst;
    pop  = (q.size() != 0) && rr;
    push = wt && ((q.size() < 16) || pop);
    drop = wt && !push;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      q.delete();
      if (clr) m_ovf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({we, wd});
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
    iWr_tick      = 1'b0;
    iRd_ready     = 1'b0;
    iFlush        = 1'b0;
    iClr_overflow = 1'b0;
    reset         = 1'b1;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    checks++; if (oRd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", oRd_valid); end
    checks++; if (oCount !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", oCount); end
    checks++; if (oFull !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", oFull); end
    checks++; if (oAlmost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", oAlmost_full); end
    checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", oOverflow); end
    step(0, 8'h00, 0, 1);
    checks++; if (oCount !== 5'd0) begin errors++; $display("FAIL empty_read_count got=%0d exp=0", oCount); end
  endtask

  task automatic test_single();
    step(1, 8'hA5, 0, 0);
    checks++; if (oRd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", oRd_valid); end
    checks++; if (oRd_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", oRd_data); end
    checks++; if (oRd_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", oRd_err); end
    checks++; if (oCount !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", oCount); end
    step(0, 8'h00, 0, 1);
    checks++; if (oCount !== 5'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", oCount); end
    checks++; if (oRd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", oRd_valid); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      checks++; if (oAlmost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_af push=%0d got=%b exp=%b", i + 1, oAlmost_full, (i + 1 >= 12)); end
      checks++; if (oCount !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", oCount, i + 1); end
    end
    checks++; if (oFull !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", oFull); end
    step(1, 8'hFF, 0, 0);
    checks++; if (oOverflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got=%b exp=1", oOverflow); end
    checks++; if (oCount !== 5'd16) begin errors++; $display("FAIL drop_count got=%0d exp=16", oCount); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (oRd_valid !== 1'b1 || oRd_data !== 8'(i)) begin errors++; $display("FAIL drain_data idx=%0d got=%h valid=%b exp=%h", i, oRd_data, oRd_valid, 8'(i)); end
      step(0, 8'h00, 0, 1);
    end
    checks++; if (oRd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", oRd_valid); end
    step(0, 8'h00, 0, 0, 0, 1);
    checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", oOverflow); end
  endtask

  task automatic test_full_simul();
    logic [7:0] last;
    for (int i = 0; i < 16; i++) step(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
    step(1, 8'h55, 0, 1);
    checks++; if (oCount !== 5'd16) begin errors++; $display("FAIL simul_count got=%0d exp=16", oCount); end
    checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got=%b exp=0", oOverflow); end
    step(1, 8'h77, 0, 0, 0, 1);
    checks++; if (oOverflow !== 1'b1) begin errors++; $display("FAIL set_beats_clr got=%b exp=1", oOverflow); end
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      checks++; if (oRd_valid !== 1'b1 || {oRd_err, oRd_data} !== q[0]) begin errors++; $display("FAIL simul_drain idx=%0d got=%h exp=%h", i, {oRd_err, oRd_data}, q[0]); end
      last = oRd_data;
      step(0, 8'h00, 0, 1);
    end
    checks++; if (last !== 8'h55) begin errors++; $display("FAIL simul_last got=%h exp=55", last); end
    step(0, 8'h00, 0, 0, 0, 1);
  endtask

  task automatic test_wrap_err();
    logic [7:0] v;
    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom_range(0, 255));
      step(1, v, 0, 0);
      checks++; if (oRd_data !== v) begin errors++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, oRd_data, v); end
      step(0, 8'h00, 0, 1);
    end
    step(1, 8'h3C, 1, 0);
    checks++; if (oRd_data !== 8'h3C) begin errors++; $display("FAIL err_data got=%h exp=3c", oRd_data); end
    checks++; if (oRd_err !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", oRd_err); end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
    checks++; if (oCount !== 5'd5) begin errors++; $display("FAIL pre_flush_count got=%0d exp=5", oCount); end
    step(1, 8'h99, 0, 1, 1);
    checks++; if (oCount !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", oCount); end
    checks++; if (oRd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", oRd_valid); end
    checks++; if (oOverflow !== 1'b1) begin errors++; $display("FAIL flush_ovf got=%b exp=1", oOverflow); end
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'hAA, 0, 0, 0, 0, 0);
    checks++; if (oCount !== 5'd0 || oRd_valid !== 1'b0 || oFull !== 1'b0 || oAlmost_full !== 1'b0 || oOverflow !== 1'b0)
      begin errors++; $display("FAIL midstream_reset got cnt=%0d v=%b f=%b af=%b ovf=%b exp all 0", oCount, oRd_valid, oFull, oAlmost_full, oOverflow); end
  endtask

  task automatic test_random();
    int rd_pct;
    for (int c = 0; c < 600; c++) begin
      rd_pct = ((c / 100) % 2 == 0) ? 20 : 75;
      step(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) != 0));
      checks++; if (oCount !== 5'(q.size())) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, oCount, q.size()); end
      checks++; if (oRd_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b", c, oRd_valid); end
      checks++; if (oFull !== (q.size() == 16)) begin errors++; $display("FAIL rand_full cyc=%0d got=%b", c, oFull); end
      checks++; if (oAlmost_full !== (q.size() >= 12)) begin errors++; $display("FAIL rand_af cyc=%0d got=%b", c, oAlmost_full); end
      checks++; if (oOverflow !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", c, oOverflow, m_ovf); end
      if (q.size() != 0) begin
        checks++; if ({oRd_err, oRd_data} !== q[0]) begin errors++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", c, {oRd_err, oRd_data}, q[0]); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; iWr_tick = 1'b0; iWr_data = '0; iWr_err = 1'b0;
    iRd_ready = 1'b0; iClr_overflow = 1'b0; iFlush = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_simul();
    test_wrap_err();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
